// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divide unit.
package div_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN
    } div_state_e;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;
    localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

endpackage

// File: rtl/add_subtract.sv
// Generic adder/subtractor: sum = a + (sub ? ~b : b) + cin, modulo 2^WIDTH.
module add_subtract #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o
);

    logic [WIDTH-1:0] b_eff;

    assign b_eff = sub_i ? ~b_i : b_i;
    assign sum_o = a_i + b_eff + WIDTH'(cin_i);

endmodule

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;
    logic           borrow;

    assign rem_sh = {rem_i, quo_i[WIDTH-1]};

    add_subtract #(
        .WIDTH (WIDTH + 1)
    ) u_sub (
        .a_i   (rem_sh),
        .b_i   ({1'b0, dvsr_i}),
        .sub_i (1'b1),
        .cin_i (1'b1),
        .sum_o (trial)
    );

    // rem_sh < 2*divisor, so the (WIDTH+1)-bit difference never wraps and its MSB is the borrow
    assign borrow = trial[WIDTH];
    assign rem_o  = borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_o  = {quo_i[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, with a one-cycle
// fast path for divide-by-zero and signed overflow.
module div_unit
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    input  logic [1:0]       i_div_op,
    output logic             o_busy,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result
);

    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    div_state_e       state_q, state_d;
    div_op_e          op_q, op_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    div_op_e          op_in;
    logic             signed_op;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             b_zero, ovf;
    logic [WIDTH-1:0] step_rem, step_quo;
    logic             is_rem;
    logic [WIDTH-1:0] fin_sel, fin_val;
    logic             fin_neg;

    // Operand decode at the start edge
    assign op_in     = div_op_e'(i_div_op);
    assign signed_op = ~i_div_op[0];
    assign a_neg     = signed_op & i_op_a[WIDTH-1];
    assign b_neg     = signed_op & i_op_b[WIDTH-1];
    assign a_abs     = a_neg ? -i_op_a : i_op_a;
    assign b_abs     = b_neg ? -i_op_b : i_op_b;
    assign b_zero    = (i_op_b == '0);
    assign ovf       = signed_op & (i_op_a == MIN_NEG) & (i_op_b == ALL_ONES);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    // Final selection and sign correction
    assign is_rem  = (op_q == REM) || (op_q == REMU);
    assign fin_sel = is_rem ? rem_q : quo_q;
    assign fin_neg = is_rem ? neg_rem_q : neg_quo_q;
    assign fin_val = fin_neg ? -fin_sel : fin_sel;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        valid_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_start && !i_flush) begin
                    op_d      = op_in;
                    dvsr_d    = b_abs;
                    neg_quo_d = (op_in == DIV) && (a_neg ^ b_neg);
                    neg_rem_d = (op_in == REM) && a_neg;
                    cnt_d     = '0;
                    // Special results are stored pre-corrected; FIN must not negate them
                    if (b_zero) begin
                        quo_d     = ALL_ONES;
                        rem_d     = i_op_a;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = FIN;
                    end else if (ovf) begin
                        quo_d     = MIN_NEG;
                        rem_d     = '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = FIN;
                    end else begin
                        quo_d   = a_abs;
                        rem_d   = '0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (i_flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
                if (!i_flush) begin
                    result_d = fin_val;
                    valid_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            op_q      <= DIV;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign o_busy   = busy_q;
    assign o_valid  = valid_q;
    assign o_result = result_q;

endmodule
